// File: rtl/rvga_pkg.sv
// rvga_pkg
// Shared types and default sizes for the register-fetch hazard controller.
// Provides the hazard FSM state enum, the pending-counter type and the
// architectural register-file dimensions used by the rvga pipeline blocks.
package rvga_pkg;

    localparam int RVGA_NUM_REGS   = 32;
    localparam int RVGA_REG_ADDR_W = 5;
    localparam int RVGA_MAX_PEND   = 3;
    localparam int RVGA_PEND_W     = $clog2(RVGA_MAX_PEND + 1);
    localparam int RVGA_STAT_W     = 32;
    localparam int RVGA_CWORD_W    = 32;

    // Control word carried in the rf->ex register; a bubble is all zeros.
    typedef logic [RVGA_CWORD_W-1:0] rvga_cword_t;

    // Number of writes in flight to one architectural register.
    typedef logic [RVGA_PEND_W-1:0] pend_cnt_t;

    // RUN issues normally; DRAIN blocks issue until every pending write retires.
    typedef enum logic {
        HZ_RUN   = 1'b0,
        HZ_DRAIN = 1'b1
    } hz_state_t;

endpackage

// File: rtl/rvga_pend_cnt.sv
// rvga_pend_cnt
// Up/down counter of outstanding writes for a single architectural register.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   inc         a write to this register was issued this cycle
//   dec         a write to this register committed this cycle
//   busy        counter is non-zero
//   sat         counter has reached MAX_PEND
//   idle_next   counter will be zero after this cycle's update
//   underflow   commit arrived while counter was already zero
module rvga_pend_cnt
    import rvga_pkg::*;
#(
    parameter int MAX_PEND = RVGA_MAX_PEND
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic busy,
    output logic sat,
    output logic idle_next,
    output logic underflow
);

    localparam int W = $clog2(MAX_PEND + 1);

    logic [W-1:0] count;
    logic [W-1:0] count_next;

    // Simultaneous issue and commit cancel. The saturation guard only matters
    // if the sat hazard were bypassed; the zero guard keeps a stray commit from
    // wrapping the counter.
    always_comb begin
        count_next = count;
        if (inc && !dec && count != W'(MAX_PEND)) begin
            count_next = count + W'(1);
        end else if (dec && !inc && count != '0) begin
            count_next = count - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    assign busy      = (count != '0);
    assign sat       = (count == W'(MAX_PEND));
    assign idle_next = (count_next == '0);
    assign underflow = dec & (count == '0);

endmodule

// File: rtl/rvga_hazard_ctrl.sv
// rvga_hazard_ctrl
// Scoreboard-based hazard controller sequencing the register-fetch stage.
// Ports:
//   clk, rst_n                 clock and synchronous active-low reset
//   ext_stall                  global pipeline freeze
//   flush                      drain all pending writes before issuing again
//   de_*                       instruction presented by decode
//   wb_*                       writeback slot
//   pipe_stall                 register-fetch stall (mirrors ext_stall)
//   front_stall                hold fetch/decode
//   bubble                     load an all-zero cword into rf->ex this cycle
//   issue                      decoded instruction accepted this cycle
//   busy_vec                   per-register "write pending" flags
//   underflow_err              sticky: commit with no pending write
//   stall_cycles               saturating count of front_stall cycles
module rvga_hazard_ctrl
    import rvga_pkg::*;
#(
    parameter int NUM_REGS   = RVGA_NUM_REGS,
    parameter int REG_ADDR_W = RVGA_REG_ADDR_W,
    parameter int MAX_PEND   = RVGA_MAX_PEND,
    parameter int STAT_W     = RVGA_STAT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ext_stall,
    input  logic                  flush,
    input  logic                  de_valid,
    input  logic [REG_ADDR_W-1:0] de_rs1,
    input  logic [REG_ADDR_W-1:0] de_rs2,
    input  logic                  de_use_rs1,
    input  logic                  de_use_rs2,
    input  logic [REG_ADDR_W-1:0] de_rd,
    input  logic                  de_regfile_load,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_regfile_load,
    output logic                  pipe_stall,
    output logic                  front_stall,
    output logic                  bubble,
    output logic                  issue,
    output logic [NUM_REGS-1:0]   busy_vec,
    output logic                  underflow_err,
    output logic [STAT_W-1:0]     stall_cycles
);

    hz_state_t           state;
    logic [NUM_REGS-1:0] sat_vec;
    logic [NUM_REGS-1:0] idle_next_vec;
    logic [NUM_REGS-1:0] uf_vec;
    logic                raw;
    logic                sat;
    logic                hazard;
    logic                draining;
    logic                inc;
    logic                dec;
    logic                all_idle_next;

    // Register 0 is hardwired zero and never tracked.
    assign busy_vec[0]      = 1'b0;
    assign sat_vec[0]       = 1'b0;
    assign idle_next_vec[0] = 1'b1;
    assign uf_vec[0]        = 1'b0;

    generate
        for (genvar r = 1; r < NUM_REGS; r++) begin : g_pend
            rvga_pend_cnt #(
                .MAX_PEND (MAX_PEND)
            ) u_cnt (
                .clk       (clk),
                .rst_n     (rst_n),
                .inc       (inc & (de_rd == REG_ADDR_W'(r))),
                .dec       (dec & (wb_rd == REG_ADDR_W'(r))),
                .busy      (busy_vec[r]),
                .sat       (sat_vec[r]),
                .idle_next (idle_next_vec[r]),
                .underflow (uf_vec[r])
            );
        end
    endgenerate

    // No bypass: a register retiring this cycle is still busy until the edge.
    assign raw = de_valid & ((de_use_rs1 & (de_rs1 != '0) & busy_vec[de_rs1]) |
                             (de_use_rs2 & (de_rs2 != '0) & busy_vec[de_rs2]));
    assign sat = de_valid & de_regfile_load & (de_rd != '0) & sat_vec[de_rd];
    assign hazard = raw | sat;

    // A flush blocks the instruction at decode in the same cycle it arrives,
    // so it is treated as draining already.
    assign draining = (state == HZ_DRAIN) | flush;

    assign pipe_stall  = ext_stall;
    assign front_stall = ext_stall | hazard | draining;
    assign bubble      = ~ext_stall & de_valid & (hazard | draining);
    assign issue       = de_valid & ~front_stall;

    // Writeback only commits while register fetch is moving.
    assign inc = issue & de_regfile_load & (de_rd != '0);
    assign dec = wb_valid & wb_regfile_load & (wb_rd != '0) & ~ext_stall;

    assign all_idle_next = &idle_next_vec;

    // Drain FSM; frozen entirely while the pipeline is externally stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= HZ_RUN;
        end else if (!ext_stall) begin
            case (state)
                HZ_RUN:   if (flush) state <= HZ_DRAIN;
                HZ_DRAIN: if (all_idle_next) state <= HZ_RUN;
                default:  state <= HZ_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            underflow_err <= 1'b0;
        end else if (|uf_vec) begin
            underflow_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (front_stall && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + STAT_W'(1);
        end
    end

endmodule

// File: tb/tb_rvga_hazard_ctrl.sv
// tb_rvga_hazard_ctrl
// Self-checking bench: directed scenarios with hand-computed expectations plus
// a randomized phase, all compared every cycle against a behavioural model
// that tracks per-register pending-write counts with plain integers.
module tb_rvga_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ext_stall;
    logic        flush;
    logic        de_valid;
    logic [4:0]  de_rs1;
    logic [4:0]  de_rs2;
    logic        de_use_rs1;
    logic        de_use_rs2;
    logic [4:0]  de_rd;
    logic        de_regfile_load;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_regfile_load;
    logic        pipe_stall;
    logic        front_stall;
    logic        bubble;
    logic        issue;
    logic [31:0] busy_vec;
    logic        underflow_err;
    logic [31:0] stall_cycles;

    rvga_hazard_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ext_stall       (ext_stall),
        .flush           (flush),
        .de_valid        (de_valid),
        .de_rs1          (de_rs1),
        .de_rs2          (de_rs2),
        .de_use_rs1      (de_use_rs1),
        .de_use_rs2      (de_use_rs2),
        .de_rd           (de_rd),
        .de_regfile_load (de_regfile_load),
        .wb_valid        (wb_valid),
        .wb_rd           (wb_rd),
        .wb_regfile_load (wb_regfile_load),
        .pipe_stall      (pipe_stall),
        .front_stall     (front_stall),
        .bubble          (bubble),
        .issue           (issue),
        .busy_vec        (busy_vec),
        .underflow_err   (underflow_err),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    // Behavioural model state.
    int          pend [32];
    bit          m_drain;
    bit          m_uf;
    logic [31:0] m_stall;
    bit          e_front;
    bit          e_bubble;
    bit          e_issue;

    int n_checks = 0;
    int n_fail   = 0;

    // One comparison; every failure prints a single FAIL line.
    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit readsPending(input bit use_it, input logic [4:0] r);
        return use_it && (r != 0) && (pend[r] > 0);
    endfunction

    // Expected combinational outputs from model state and current inputs.
    task automatic modelComb();
        bit hz;
        hz = de_valid && (readsPending(de_use_rs1, de_rs1) || readsPending(de_use_rs2, de_rs2));
        if (de_valid && de_regfile_load && de_rd != 0 && pend[de_rd] == 3) hz = 1;
        e_front  = ext_stall || hz || m_drain || flush;
        e_bubble = !ext_stall && de_valid && (hz || m_drain || flush);
        e_issue  = de_valid && !e_front;
    endtask

    // Advance the model across one clock edge using the inputs just checked.
    task automatic modelUpdate();
        int  inc_r;
        int  dec_r;
        bit  empty;
        if (!rst_n) begin
            foreach (pend[r]) pend[r] = 0;
            m_drain = 0;
            m_uf    = 0;
            m_stall = 0;
            return;
        end
        if (e_front && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        if (ext_stall) return;
        inc_r = (e_issue && de_regfile_load && de_rd != 0) ? int'(de_rd) : -1;
        dec_r = (wb_valid && wb_regfile_load && wb_rd != 0) ? int'(wb_rd) : -1;
        if (dec_r >= 0 && pend[dec_r] == 0) m_uf = 1;
        if (dec_r >= 0 && dec_r != inc_r && pend[dec_r] > 0) pend[dec_r]--;
        if (inc_r >= 0 && inc_r != dec_r) pend[inc_r]++;
        empty = 1;
        foreach (pend[r]) if (pend[r] != 0) empty = 0;
        if (m_drain) begin
            if (empty) m_drain = 0;
        end else if (flush) begin
            m_drain = 1;
        end
    endtask

    task automatic checkOutput();
        logic [31:0] e_busy;
        modelComb();
        e_busy = '0;
        for (int r = 1; r < 32; r++) if (pend[r] > 0) e_busy[r] = 1'b1;
        cmp("pipe_stall",    pipe_stall,    ext_stall);
        cmp("front_stall",   front_stall,   e_front);
        cmp("bubble",        bubble,        e_bubble);
        cmp("issue",         issue,         e_issue);
        cmp("busy_vec",      busy_vec,      e_busy);
        cmp("underflow_err", underflow_err, m_uf);
        cmp("stall_cycles",  stall_cycles,  m_stall);
    endtask

    // Inputs are set at the falling edge; check, clock, update the model.
    task automatic applyStimulus();
        #1;
        checkOutput();
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
    endtask

    task automatic setIdle();
        rst_n = 1; ext_stall = 0; flush = 0;
        de_valid = 0; de_rs1 = 0; de_rs2 = 0; de_use_rs1 = 0; de_use_rs2 = 0;
        de_rd = 0; de_regfile_load = 0;
        wb_valid = 0; wb_rd = 0; wb_regfile_load = 0;
    endtask

    task automatic setDecode(input logic v, input logic [4:0] rs1, input logic u1,
                             input logic [4:0] rs2, input logic u2,
                             input logic [4:0] rd, input logic ld);
        de_valid = v; de_rs1 = rs1; de_use_rs1 = u1; de_rs2 = rs2; de_use_rs2 = u2;
        de_rd = rd; de_regfile_load = ld;
    endtask

    task automatic setWb(input logic v, input logic [4:0] rd, input logic ld);
        wb_valid = v; wb_rd = rd; wb_regfile_load = ld;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] s0;
        int          q[$];

        setIdle();
        rst_n = 0;
        foreach (pend[r]) pend[r] = 0;
        m_drain = 0; m_uf = 0; m_stall = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;

        // Reset state
        #1;
        cmp("rst_busy", busy_vec, 32'h0);
        cmp("rst_front", front_stall, 1'b0);
        cmp("rst_issue", issue, 1'b0);
        cmp("rst_stall_cnt", stall_cycles, 32'd0);
        cmp("rst_uf", underflow_err, 1'b0);
        applyStimulus();

        // RAW on r5
        $display("[TB] RAW scenario");
        setDecode(1, 0, 0, 0, 0, 5, 1);
        #1; cmp("raw_first_issue", issue, 1'b1);
        applyStimulus();
        setDecode(1, 5, 1, 0, 0, 6, 0);
        #1; cmp("raw_bubble", bubble, 1'b1); cmp("raw_busy5", busy_vec[5], 1'b1);
        applyStimulus();
        setWb(1, 5, 1);
        #1; cmp("raw_bubble_wb_cycle", bubble, 1'b1);
        applyStimulus();
        setWb(0, 0, 0);
        #1; cmp("raw_dep_issue", issue, 1'b1); cmp("raw_no_bubble", bubble, 1'b0);
        applyStimulus();
        setIdle();
        #1; cmp("raw_stall_count", stall_cycles, 32'd2);
        applyStimulus();

        // Register 0 chain
        $display("[TB] x0 scenario");
        for (int i = 0; i < 3; i++) begin
            setDecode(1, 0, 1, 0, 1, 0, 1);
            #1; cmp("x0_front", front_stall, 1'b0); cmp("x0_busy", busy_vec, 32'h0);
            applyStimulus();
        end

        // Saturation on r7
        $display("[TB] saturation scenario");
        for (int i = 0; i < 3; i++) begin
            setDecode(1, 0, 0, 0, 0, 7, 1);
            applyStimulus();
        end
        #1; cmp("sat_stall", front_stall, 1'b1); cmp("sat_no_issue", issue, 1'b0);
        applyStimulus();
        setWb(1, 7, 1);
        applyStimulus();
        setWb(0, 0, 0);
        #1; cmp("sat_release_issue", issue, 1'b1);
        applyStimulus();
        setIdle();
        setWb(1, 7, 1);
        for (int i = 0; i < 3; i++) applyStimulus();
        setIdle();
        #1; cmp("sat_clear", busy_vec[7], 1'b0);

        // Simultaneous issue and retire on r9
        $display("[TB] simultaneous scenario");
        setDecode(1, 0, 0, 0, 0, 9, 1);
        applyStimulus();
        setWb(1, 9, 1);
        #1; cmp("sim_issue", issue, 1'b1);
        applyStimulus();
        setIdle();
        #1; cmp("sim_busy9", busy_vec[9], 1'b1);
        setWb(1, 9, 1);
        applyStimulus();
        setIdle();

        // Flush with two writes pending
        $display("[TB] flush scenario");
        setDecode(1, 0, 0, 0, 0, 10, 1); applyStimulus();
        setDecode(1, 0, 0, 0, 0, 11, 1); applyStimulus();
        setDecode(1, 0, 0, 0, 0, 12, 1); flush = 1;
        #1; cmp("flush_no_issue", issue, 1'b0);
        applyStimulus();
        flush = 0; setWb(1, 10, 1);
        #1; cmp("drain_bubble1", bubble, 1'b1);
        applyStimulus();
        setWb(1, 11, 1);
        #1; cmp("drain_bubble2", bubble, 1'b1);
        applyStimulus();
        setWb(0, 0, 0); setDecode(1, 0, 0, 0, 0, 0, 0);
        #1; cmp("drain_resume", issue, 1'b1);
        applyStimulus();
        setIdle();

        // ext_stall during a RAW hazard on r5
        $display("[TB] ext_stall scenario");
        setDecode(1, 0, 0, 0, 0, 5, 1); applyStimulus();
        setDecode(1, 5, 1, 0, 0, 0, 0); setWb(1, 5, 1); ext_stall = 1;
        s0 = m_stall;
        for (int i = 0; i < 4; i++) begin
            #1; cmp("ext_bubble", bubble, 1'b0); cmp("ext_front", front_stall, 1'b1);
            applyStimulus();
        end
        #1; cmp("ext_stall_cnt", stall_cycles, s0 + 32'd4); cmp("ext_frozen", busy_vec[5], 1'b1);
        ext_stall = 0;
        applyStimulus();
        setWb(0, 0, 0);
        applyStimulus();
        setIdle();

        // Reset mid-DRAIN with r3 pending, then a stray commit
        $display("[TB] reset scenario");
        setDecode(1, 0, 0, 0, 0, 3, 1); applyStimulus();
        setIdle(); flush = 1; applyStimulus();
        setIdle(); rst_n = 0; applyStimulus();
        setIdle();
        #1; cmp("rst_mid_busy", busy_vec, 32'h0); cmp("rst_mid_uf", underflow_err, 1'b0);
        setWb(1, 3, 1);
        applyStimulus();
        setIdle();
        #1; cmp("stray_uf", underflow_err, 1'b1);
        rst_n = 0; applyStimulus();
        setIdle();

        // Randomized traffic; commits only target registers the model holds pending.
        $display("[TB] random phase");
        for (int c = 0; c < 2500; c++) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            ext_stall = ($urandom_range(0, 9) == 0);
            flush     = ($urandom_range(0, 49) == 0);
            setDecode($urandom_range(0, 9) < 7,
                      5'($urandom_range(0, 7)), 1'($urandom),
                      5'($urandom_range(0, 7)), 1'($urandom),
                      5'($urandom_range(0, 7)), $urandom_range(0, 9) < 6);
            q.delete();
            for (int r = 1; r < 32; r++) if (pend[r] > 0) q.push_back(r);
            if (q.size() > 0 && $urandom_range(0, 9) < 5)
                setWb(1, 5'(q[$urandom_range(0, q.size() - 1)]), 1);
            else
                setWb(1'($urandom), 0, 1'($urandom));
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
